mem_access_sequencer: RTL and testbench
=======================================

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have ports `clock`, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have ports `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports `req_valid`, input, 1 bit: request present.
REQ-004 SHALL have ports `req_ready`, output, 1 bit: high only in IDLE.
REQ-005 SHALL have ports `req_rw`, input, 1 bit: 1 = load, 0 = store.
REQ-006 SHALL have ports `req_size`, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 SHALL have ports `req_signed`, input, 1 bit: sign-extend load result.
REQ-008 SHALL have ports `req_addr`, input, 9 bits: byte address.
REQ-009 SHALL have ports `req_wdata`, input, 32 bits: store data, right-justified.
REQ-010 SHALL have ports `ram_en`, output, 1 bit: one-cycle strobe per byte access to the 512x8 RAM.
REQ-011 SHALL have ports `ram_r_w`, output, 1 bit: 1 = read, 0 = write.
REQ-012 SHALL have ports `ram_addr`, output, 9 bits, and `ram_wdata`, output, 8 bits.
REQ-013 SHALL have ports `ram_rdata`, input, 8 bits: valid in the cycle after the `ram_en` cycle.
REQ-014 SHALL have ports `resp_valid`, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have ports `resp_rdata`, output, 32 bits, and `resp_err`, output, 1 bit.

Function
REQ-016 SHALL implement states IDLE, ISSUE, CAPTURE and DONE.
REQ-017 SHALL accept a request at edge T when `req_valid` and `req_ready` are both high; `req_valid` while busy SHALL be ignored, not queued.
REQ-018 SHALL latch the address, size, rw, signed and wdata fields at acceptance; later input changes have no effect on the operation.
REQ-019 SHALL derive the byte count N from `req_size`: 1, 2 or 4.
REQ-020 SHALL flag a request as erroneous if `req_size` = 11, or a half has `addr[0]` = 1, or a word has `addr[1:0]` != 00.
REQ-021 SHALL, for an erroneous request, go IDLE -> DONE with no `ram_en` ever asserted; `resp_valid` = 1, `resp_err` = 1 and `resp_rdata` = 0 in cycle T+1.
REQ-022 SHALL, for a legal request, perform byte k (k = 0..N-1) as an ISSUE cycle followed by a CAPTURE cycle.
REQ-023 SHALL, in ISSUE, drive `ram_en` = 1, `ram_addr` = base + k, and `ram_r_w` = the latched rw.
REQ-024 SHALL, in ISSUE for a store, drive `ram_wdata` = byte (N-1-k) of wdata (big-endian: lowest address holds the most significant byte).
REQ-025 SHALL, in CAPTURE for a load, sample `ram_rdata` into lane (N-1-k).
REQ-026 SHALL transition CAPTURE -> ISSUE when k < N-1, and CAPTURE -> DONE after the last byte.
REQ-027 SHALL produce `resp_valid` in cycle T+2N+1: byte at T+3, half at T+5, word at T+9.
REQ-028 SHALL hold DONE for exactly one cycle, then return to IDLE; the earliest next acceptance is the edge ending the first IDLE cycle.
REQ-029 SHALL form the load result from the assembled 8N bits: sign-extended from bit 8N-1 if signed, zero-extended otherwise.
REQ-030 SHALL set `resp_rdata` = 0 for stores; `resp_err` = 0 on every legal completion.
REQ-031 SHALL hold `resp_rdata` and `resp_err` from DONE until the next DONE.
REQ-032 SHALL drive `ram_en` = 0 in all non-ISSUE states.
REQ-033 SHALL hold the last driven values of `ram_addr`, `ram_wdata` and `ram_r_w` outside ISSUE.
REQ-034 SHALL never need address wrap-around: aligned accesses end at or below 511 (word at 508 spans 508..511).

Reset
REQ-035 SHALL, while `reset_n` = 0, immediately force state = IDLE, `ram_en` = 0, `ram_r_w` = 1, `ram_addr` = 0, `ram_wdata` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0 and `req_ready` = 1.
REQ-036 SHALL, on reset mid-operation, abandon the operation with no response; store bytes already written remain in RAM.
REQ-037 SHALL process the first request after reset release normally.

Verification
REQ-038 SHALL verify a word load: RAM[4..7] = 12,34,56,78; load at addr 4 -> `ram_en` at T+1, T+3, T+5, T+7 with addr 4..7; `resp_valid` at T+9; `resp_rdata` = 32'h12345678.
REQ-039 SHALL verify signed and unsigned byte loads: RAM[3] = F0; signed load -> 32'hFFFFFFF0 at T+3; unsigned load -> 32'h000000F0.
REQ-040 SHALL verify a half store and readback: store 32'h0000ABCD at addr 10 -> RAM[10] = AB, RAM[11] = CD, RAM[9] and RAM[12] unchanged; signed half load at addr 10 -> 32'hFFFFABCD.
REQ-041 SHALL verify error paths: word at addr 6, half at addr 1, and `req_size` = 11 each give `resp_err` = 1 and `resp_rdata` = 0 at T+1, with no `ram_en`.
REQ-042 SHALL verify the top boundary: word load at addr 508 -> addresses 508..511 accessed, no error.
REQ-043 SHALL verify reset mid-operation: `reset_n` low during ISSUE of byte 2 of a word store -> `ram_en` drops immediately, RAM[0..1] written, RAM[2..3] untouched, no `resp_valid`; the next request completes correctly.

Source files
------------

// File: rtl/mem_access_sequencer_if.sv
// Request, RAM and response signals of the byte-serial memory access sequencer.
// The slave modport is the sequencer's view; the master modport is the requester/RAM side.
interface mem_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;

    logic        ram_en;
    logic        ram_r_w;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport slave (
        input  req_valid, req_rw, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        output req_ready, ram_en, ram_r_w, ram_addr, ram_wdata, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_rw, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        input  req_ready, ram_en, ram_r_w, ram_addr, ram_wdata, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Splits byte/half/word loads and stores into big-endian byte accesses on a 512x8 RAM,
// one ISSUE + CAPTURE pair per byte, then reports the assembled result for one cycle.
module mem_access_sequencer (
    input  logic                         clock,
    input  logic                         reset_n,
    mem_access_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [8:0]  base_addr;
    logic [1:0]  last_idx;
    logic [1:0]  byte_idx;
    logic        op_rw;
    logic        op_signed;
    logic [31:0] op_wdata;
    logic [31:0] assembled;

    logic [8:0]  ram_addr_q;
    logic [7:0]  ram_wdata_q;
    logic        ram_r_w_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        req_err;
    logic [1:0]  req_last;
    logic [1:0]  lane;
    logic [1:0]  next_idx;
    logic [1:0]  next_lane;
    logic [7:0]  first_wbyte;
    logic [7:0]  next_wbyte;
    logic [31:0] merged;
    logic [31:0] load_result;

    // Decode the incoming request: index of its last byte and whether it is misaligned/illegal.
    always_comb begin
        req_err  = 1'b0;
        req_last = 2'd0;
        case (bus.req_size)
            2'b00: req_last = 2'd0;
            2'b01: begin
                req_last = 2'd1;
                req_err  = bus.req_addr[0];
            end
            2'b10: begin
                req_last = 2'd3;
                req_err  = |bus.req_addr[1:0];
            end
            default: req_err = 1'b1;
        endcase
    end

    // Byte k travels in lane (N-1-k), so the lowest address carries the most significant byte.
    always_comb begin
        lane        = last_idx - byte_idx;
        next_idx    = byte_idx + 2'd1;
        next_lane   = last_idx - next_idx;
        first_wbyte = bus.req_wdata[{req_last, 3'b000} +: 8];
        next_wbyte  = op_wdata[{next_lane, 3'b000} +: 8];
        merged      = assembled;
        merged[{lane, 3'b000} +: 8] = bus.ram_rdata;
    end

    always_comb begin
        load_result = merged;
        case (last_idx)
            2'd0:    load_result = {{24{op_signed & merged[7]}}, merged[7:0]};
            2'd1:    load_result = {{16{op_signed & merged[15]}}, merged[15:0]};
            default: load_result = merged;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Errored requests skip the RAM entirely and go straight to the response cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = req_err ? DONE : ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = (byte_idx == last_idx) ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM address/data are registered one edge ahead of each ISSUE cycle and held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_addr    <= '0;
            last_idx     <= '0;
            byte_idx     <= '0;
            op_rw        <= 1'b0;
            op_signed    <= 1'b0;
            op_wdata     <= '0;
            assembled    <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_r_w_q    <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base_addr <= bus.req_addr;
                        last_idx  <= req_last;
                        byte_idx  <= 2'd0;
                        op_rw     <= bus.req_rw;
                        op_signed <= bus.req_signed;
                        op_wdata  <= bus.req_wdata;
                        assembled <= '0;
                        if (req_err) begin
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                        end else begin
                            ram_addr_q  <= bus.req_addr;
                            ram_r_w_q   <= bus.req_rw;
                            ram_wdata_q <= first_wbyte;
                        end
                    end
                end
                CAPTURE: begin
                    if (op_rw) assembled <= merged;
                    if (byte_idx == last_idx) begin
                        resp_rdata_q <= op_rw ? load_result : 32'd0;
                        resp_err_q   <= 1'b0;
                    end else begin
                        byte_idx    <= next_idx;
                        ram_addr_q  <= base_addr + {7'd0, next_idx};
                        ram_wdata_q <= next_wbyte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.ram_en     = (state == ISSUE);
    assign bus.resp_valid = (state == DONE);
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.ram_r_w    = ram_r_w_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench: a 512x8 RAM model plus scoreboards of expected RAM accesses
// and responses, filled when a request is driven and drained as the DUT produces them.
module tb_mem_access_sequencer;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [8:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } acc_t;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   fails  = 0;

    resp_t resp_q[$];
    acc_t  acc_q[$];
    acc_t  mon_exp;
    logic [7:0] mem [512];

    mem_access_sequencer_if bus();

    mem_access_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // RAM model: read data appears in the cycle after the enable cycle.
    always @(posedge clock) begin
        if (bus.ram_en === 1'b1) begin
            if (bus.ram_r_w) bus.ram_rdata <= mem[bus.ram_addr];
            else             mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    // Every RAM strobe must match the next expected access; a strobe with none expected is an error.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && bus.ram_en === 1'b1) begin
            checks++;
            if (acc_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL ram_access: unexpected ram_en addr=%0d r_w=%0b", bus.ram_addr, bus.ram_r_w);
            end else begin
                mon_exp = acc_q.pop_front();
                if (bus.ram_addr !== mon_exp.addr || bus.ram_r_w !== mon_exp.rw ||
                    (!mon_exp.rw && bus.ram_wdata !== mon_exp.wdata)) begin
                    fails++;
                    $display("[TB] FAIL ram_access: got addr=%0d r_w=%0b wdata=%h, expected addr=%0d r_w=%0b wdata=%h",
                             bus.ram_addr, bus.ram_r_w, bus.ram_wdata, mon_exp.addr, mon_exp.rw, mon_exp.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at a negedge; returns one tick after the acceptance edge with the inputs scrambled.
    task automatic send(input logic rw, input logic [1:0] size, input logic sgn, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        output int waits);
        int    n;
        acc_t  a;
        resp_t r;
        bus.req_rw     = rw;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        waits = 0;
        while (bus.req_ready !== 1'b1 && waits < 20) begin
            @(negedge clock);
            waits++;
        end
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        if (!exp_err) begin
            for (int k = 0; k < n; k++) begin
                a.addr  = addr + 9'(k);
                a.rw    = rw;
                a.wdata = wdata[8*(n-1-k) +: 8];
                acc_q.push_back(a);
            end
        end
        r.rdata = exp_rdata;
        r.err   = exp_err;
        resp_q.push_back(r);
        @(posedge clock);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_rw     = ~rw;
        bus.req_size   = ~size;
        bus.req_signed = ~sgn;
        bus.req_addr   = ~addr;
        bus.req_wdata  = ~wdata;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (bus.resp_valid !== 1'b1 && lat < 40);
        rd = bus.resp_rdata;
        er = bus.resp_err;
    endtask

    task automatic test_reset();
        bus.req_valid  = 1'b0;
        bus.req_rw     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.req_ready, bus.ram_en, bus.ram_r_w, bus.ram_addr, bus.ram_wdata,
             bus.resp_valid, bus.resp_rdata, bus.resp_err} !==
            {1'b1, 1'b0, 1'b1, 9'd0, 8'd0, 1'b0, 32'd0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL reset_values: ready=%b en=%b r_w=%b addr=%0d wdata=%h valid=%b rdata=%h err=%b",
                     bus.req_ready, bus.ram_en, bus.ram_r_w, bus.ram_addr, bus.ram_wdata,
                     bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_word_load();
        logic [31:0] rd;
        logic        er;
        int          lat, w;
        resp_t       e;
        mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'h56; mem[7] = 8'h78;
        @(negedge clock);
        send(1'b1, 2'b10, 1'b0, 9'd4, 32'h0, 32'h12345678, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 9) begin
            fails++;
            $display("[TB] FAIL word_load: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=9", rd, er, lat, e.rdata, e.err);
        end
        @(negedge clock);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'h12345678 || acc_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL word_load_after: valid=%b ready=%b rdata=%h pending_acc=%0d, expected 0 1 12345678 0",
                     bus.resp_valid, bus.req_ready, bus.resp_rdata, acc_q.size());
        end
    endtask

    task automatic test_byte_loads();
        logic [31:0] rd;
        logic        er;
        int          lat, w;
        resp_t       e;
        mem[3] = 8'hF0;
        @(negedge clock);
        send(1'b1, 2'b00, 1'b1, 9'd3, 32'h0, 32'hFFFFFFF0, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 3) begin
            fails++;
            $display("[TB] FAIL byte_load_signed: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=3", rd, er, lat, e.rdata, e.err);
        end
        send(1'b1, 2'b00, 1'b0, 9'd3, 32'h0, 32'h000000F0, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 3) begin
            fails++;
            $display("[TB] FAIL byte_load_unsigned: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=3", rd, er, lat, e.rdata, e.err);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] rd;
        logic        er;
        int          lat, w;
        resp_t       e;
        mem[9] = 8'h11; mem[10] = 8'h00; mem[11] = 8'h00; mem[12] = 8'h22;
        @(negedge clock);
        send(1'b0, 2'b01, 1'b0, 9'd10, 32'h0000ABCD, 32'h0, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 5) begin
            fails++;
            $display("[TB] FAIL half_store: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=5", rd, er, lat, e.rdata, e.err);
        end
        checks++;
        if ({mem[9], mem[10], mem[11], mem[12]} !== 32'h11ABCD22) begin
            fails++;
            $display("[TB] FAIL half_store_ram: RAM[9..12]=%h %h %h %h, expected 11 ab cd 22", mem[9], mem[10], mem[11], mem[12]);
        end
        send(1'b1, 2'b01, 1'b1, 9'd10, 32'h0, 32'hFFFFABCD, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 5) begin
            fails++;
            $display("[TB] FAIL half_readback: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=5", rd, er, lat, e.rdata, e.err);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat, w;
        resp_t       e;
        logic [1:0]  sizes [3];
        logic [8:0]  addrs [3];
        sizes[0] = 2'b10; addrs[0] = 9'd6;
        sizes[1] = 2'b01; addrs[1] = 9'd1;
        sizes[2] = 2'b11; addrs[2] = 9'd0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, sizes[i], 1'b1, addrs[i], 32'hFFFFFFFF, 32'h0, 1'b1, w);
            wait_resp(rd, er, lat);
            e = resp_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err || lat != 1) begin
                fails++;
                $display("[TB] FAIL error_path_%0d: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=1", i, rd, er, lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd;
        logic        er;
        int          lat, w;
        resp_t       e;
        mem[508] = 8'h80; mem[509] = 8'h01; mem[510] = 8'h02; mem[511] = 8'h03;
        @(negedge clock);
        send(1'b1, 2'b10, 1'b1, 9'd508, 32'h0, 32'h80010203, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 9 || acc_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL top_boundary: rdata=%h err=%b lat=%0d pending_acc=%0d, expected rdata=%h err=%b lat=9 pending_acc=0",
                     rd, er, lat, acc_q.size(), e.rdata, e.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          lat, w;
        resp_t       e;
        logic [7:0]  keep;
        keep = mem[100];
        mem[20] = 8'h7E;
        @(negedge clock);
        send(1'b1, 2'b00, 1'b1, 9'd20, 32'h0, 32'h0000007E, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 3) begin
            fails++;
            $display("[TB] FAIL b2b_first: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=3", rd, er, lat, e.rdata, e.err);
        end
        // Presented during DONE: must wait exactly the one IDLE cycle.
        send(1'b1, 2'b00, 1'b0, 9'd20, 32'h0, 32'h0000007E, 1'b0, w);
        checks++;
        if (w != 1) begin
            fails++;
            $display("[TB] FAIL b2b_accept_delay: waited %0d cycles, expected 1", w);
        end
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 9'd100;
        bus.req_wdata = 32'h000000A5;
        @(negedge clock);
        bus.req_valid = 1'b0;
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 2) begin
            fails++;
            $display("[TB] FAIL b2b_second: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=2", rd, er, lat, e.rdata, e.err);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || mem[100] !== keep) begin
            fails++;
            $display("[TB] FAIL busy_ignored: ready=%b valid=%b RAM[100]=%h, expected 1 0 %h", bus.req_ready, bus.resp_valid, mem[100], keep);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd;
        logic        er;
        int          lat, w;
        bit          saw_valid;
        resp_t       e;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h55; mem[3] = 8'h66;
        saw_valid = 1'b0;
        @(negedge clock);
        send(1'b0, 2'b10, 1'b0, 9'd0, 32'hA1B2C3D4, 32'h0, 1'b0, w);
        repeat (4) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.ram_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.ram_r_w !== 1'b1 || bus.ram_addr !== 9'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_op: en=%b ready=%b r_w=%b addr=%0d, expected 0 1 1 0",
                     bus.ram_en, bus.req_ready, bus.ram_r_w, bus.ram_addr);
        end
        acc_q.delete();
        resp_q.delete();
        repeat (2) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b0) saw_valid = 1'b1;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.resp_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || {mem[0], mem[1], mem[2], mem[3]} !== 32'hA1B25566) begin
            fails++;
            $display("[TB] FAIL reset_abandon: resp_valid_seen=%b RAM[0..3]=%h %h %h %h, expected 0 and a1 b2 55 66",
                     saw_valid, mem[0], mem[1], mem[2], mem[3]);
        end
        send(1'b1, 2'b10, 1'b0, 9'd0, 32'h0, 32'hA1B25566, 1'b0, w);
        wait_resp(rd, er, lat);
        e = resp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != 9) begin
            fails++;
            $display("[TB] FAIL after_reset_load: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=9", rd, er, lat, e.rdata, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_loads();
        test_half_store();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_reset_mid_op();
        repeat (2) @(negedge clock);
        checks++;
        if (acc_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_accesses: %0d expected RAM accesses never seen, expected 0", acc_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
